// File: rtl/de0_nano_boot_prefetch.sv
// One-line read-only Wishbone prefetch buffer between the CPU instruction bus and the boot ROM.
// Define BOOT_PREFETCH_CWF_EN to refill critical-word-first and answer the CPU as soon as that word lands.
//
// state | meaning
// IDLE  | serve hits, flag writes, start a refill on a miss
// FILL  | single-word ROM reads into the line, one per ROM ack
// RESP  | line complete; answer the waiting CPU request if it is still there
module de0_nano_boot_prefetch #(
  parameter int LINE_WORDS = 4,
  parameter int WB_AW      = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WB_AW-1:0] s_wb_adr_i,
  input  logic             s_wb_cyc_i,
  input  logic             s_wb_stb_i,
  input  logic             s_wb_we_i,
  output logic [31:0]      s_wb_dat_o,
  output logic             s_wb_ack_o,
  output logic             s_wb_err_o,
  output logic [WB_AW-1:0] m_wb_adr_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  input  logic [31:0]      m_wb_dat_i,
  input  logic             m_wb_ack_i
);
  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int TAGW = WB_AW - OFFW - 2;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

  state_e                      state_q, state_d;
  logic                        valid_q, valid_d;
  logic [TAGW-1:0]             tag_q, tag_d;
  logic [OFFW-1:0]             off_q, off_d;
  logic [OFFW-1:0]             cnt_q, cnt_d;
  logic [LINE_WORDS-1:0][31:0] line_q, line_d;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic [31:0]                 dat_q, dat_d;

  logic            req, hit, last_word;
  logic [TAGW-1:0] adr_tag;
  logic [OFFW-1:0] adr_off;
  logic            unused_adr;

  assign adr_tag    = s_wb_adr_i[WB_AW-1:OFFW+2];
  assign adr_off    = s_wb_adr_i[OFFW+1:2];
  assign unused_adr = ^s_wb_adr_i[1:0];
  // The registered ack/err masks the request so each request gets exactly one pulse.
  assign req = s_wb_cyc_i & s_wb_stb_i & ~ack_q & ~err_q;
  assign hit = valid_q && (tag_q == adr_tag);

`ifdef BOOT_PREFETCH_CWF_EN
  assign last_word = (cnt_q + OFFW'(1)) == off_q;
`else
  assign last_word = cnt_q == OFFW'(LINE_WORDS - 1);
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (s_wb_we_i) begin
            err_d = 1'b1;
          end else if (hit) begin
            ack_d = 1'b1;
            dat_d = line_q[adr_off];
          end else begin
            tag_d   = adr_tag;
            off_d   = adr_off;
            valid_d = 1'b0;
`ifdef BOOT_PREFETCH_CWF_EN
            cnt_d   = adr_off;
`else
            cnt_d   = '0;
`endif
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (m_wb_ack_i) begin
          line_d[cnt_q] = m_wb_dat_i;
          cnt_d         = cnt_q + OFFW'(1);
`ifdef BOOT_PREFETCH_CWF_EN
          if (cnt_q == off_q && s_wb_cyc_i && s_wb_stb_i) begin
            ack_d = 1'b1;
            dat_d = m_wb_dat_i;
          end
`endif
          if (last_word) begin
            valid_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
`ifndef BOOT_PREFETCH_CWF_EN
        if (s_wb_cyc_i && s_wb_stb_i) begin
          ack_d = 1'b1;
          dat_d = line_q[off_q];
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Address is built from the latched tag so a refill never leaves its own line.
  assign m_wb_cyc_o = (state_q == FILL);
  assign m_wb_stb_o = (state_q == FILL);
  assign m_wb_adr_o = (state_q == FILL) ? {tag_q, cnt_q, 2'b00} : '0;
  assign s_wb_ack_o = ack_q;
  assign s_wb_err_o = err_q;
  assign s_wb_dat_o = dat_q;

endmodule
